// File: rtl/uart_rx_ext_if.sv
// Parallel word output of the UART receiver: word, status flags and the valid/ready handshake.
interface uart_rx_ext_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  parity_err;
  logic                  frame_err;
  logic                  overrun;

  modport master (output data, valid, parity_err, frame_err, overrun, input ready);
  modport slave  (input data, valid, parity_err, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_rx_ext.sv
// UART receiver with oversampled 3-sample majority voting, optional parity and 1-2 stop bits.
// valid rises one cycle after the last stop-bit decision; a frame finishing while valid && !ready is dropped and flagged.
module uart_rx_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sig,
  uart_rx_ext_if.master rx
);
  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_WIDTH);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_S0    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_S1    = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  OS_S2    = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic             ODD      = (PARITY == 2);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

  state_e                state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic                  prev_q, prev_d;
  logic [2:0]            settle_q, settle_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [OS_W-1:0]       os_q, os_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  stop_q, stop_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  s0_q, s0_d, s1_q, s1_d;
  logic                  par_bad_q, par_bad_d, stop_bad_q, stop_bad_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d, parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d, overrun_q, overrun_d;

  logic cur, fall, tick, maj, done;

  assign cur  = sync_q[1];
  // The synchronizer resets high, so edges are ignored until real line samples reach prev_q.
  assign fall = prev_q & ~cur & settle_q[2];
  assign tick = (div_q == DIV_LAST);
  assign maj  = (s0_q & s1_q) | (s0_q & cur) | (s1_q & cur);

  always_comb begin
    sync_d     = {sync_q[0], sig};
    prev_d     = sync_q[1];
    settle_d   = {settle_q[1:0], 1'b1};
    state_d    = state_q;
    div_d      = div_q;
    os_d       = os_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    shift_d    = shift_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    par_bad_d  = par_bad_q;
    stop_bad_d = stop_bad_q;
    done       = 1'b0;

    if (state_q == ST_IDLE) begin
      div_d = '0;
      os_d  = '0;
      if (fall) begin
        state_d    = ST_START;
        par_bad_d  = 1'b0;
        stop_bad_d = 1'b0;
      end
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        os_d = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
        if (os_q == OS_S0) s0_d = cur;
        if (os_q == OS_S1) s1_d = cur;
        if (os_q == OS_S2) begin
          case (state_q)
            ST_START:  if (maj) state_d = ST_IDLE;
            ST_DATA:   shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
            ST_PARITY: par_bad_d = (^shift_q) ^ maj ^ ODD;
            ST_STOP: begin
              stop_bad_d = stop_bad_q | ~maj;
              // Remainder of the last stop bit is treated as idle so back-to-back frames are caught.
              if (stop_q == STOP_LAST) begin
                done    = 1'b1;
                state_d = ST_IDLE;
              end
            end
            default: ;
          endcase
        end
        if (os_q == OS_LAST) begin
          case (state_q)
            ST_START: begin
              state_d = ST_DATA;
              bit_d   = '0;
            end
            ST_DATA: begin
              if (bit_q == BIT_LAST) begin
                state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                stop_d  = 1'b0;
              end else begin
                bit_d = bit_q + 1'b1;
              end
            end
            ST_PARITY: begin
              state_d = ST_STOP;
              stop_d  = 1'b0;
            end
            ST_STOP: stop_d = stop_q + 1'b1;
            default: ;
          endcase
        end
      end
    end

    data_d       = data_q;
    valid_d      = valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    if (done) begin
      if (!valid_q || rx.ready) begin
        data_d       = shift_q;
        valid_d      = 1'b1;
        parity_err_d = par_bad_q;
        frame_err_d  = stop_bad_d;
        overrun_d    = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sync_q       <= 2'b11;
      prev_q       <= 1'b1;
      settle_q     <= '0;
      div_q        <= '0;
      os_q         <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      shift_q      <= '0;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      par_bad_q    <= 1'b0;
      stop_bad_q   <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      settle_q     <= settle_d;
      div_q        <= div_d;
      os_q         <= os_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      shift_q      <= shift_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      par_bad_q    <= par_bad_d;
      stop_bad_q   <= stop_bad_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx.data       = data_q;
  assign rx.valid      = valid_q;
  assign rx.parity_err = parity_err_q;
  assign rx.frame_err  = frame_err_q;
  assign rx.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: channel a = no parity / 1 stop, channel b = even parity / 2 stops.
module tb_uart_rx_ext;
  localparam int BAUD = 115200;
  localparam int OS   = 16;
  localparam int CLKF = BAUD * OS * 4;
  localparam int BIT  = (CLKF / (BAUD * OS)) * OS;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic sig_a  = 1'b1;
  logic sig_b  = 1'b1;
  logic rdy_a  = 1'b0;
  logic rdy_b  = 1'b0;
  logic hold_a = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  uart_rx_ext_if #(.DATA_WIDTH(8)) ia ();
  uart_rx_ext_if #(.DATA_WIDTH(8)) ib ();
  assign ia.ready = rdy_a;
  assign ib.ready = rdy_b;

  uart_rx_ext #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF), .OVERSAMPLE(OS),
                .PARITY(0), .STOP_BITS(1))
    dut_a (.clk(clk), .rst(rst), .sig(sig_a), .rx(ia));

  uart_rx_ext #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF), .OVERSAMPLE(OS),
                .PARITY(1), .STOP_BITS(2))
    dut_b (.clk(clk), .rst(rst), .sig(sig_b), .rx(ib));

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard pop and compare at the moment the consumer accepts the word.
  task automatic judge(input int ch);
    exp_t e;
    bit   have;
    logic [7:0] d;
    logic pe, fe, ov;
    string tag;
    tag = (ch == 0) ? "a" : "b";
    e = '0;
    if (ch == 0) begin
      have = (qa.size() != 0);
      if (have) e = qa.pop_front();
      d = ia.data; pe = ia.parity_err; fe = ia.frame_err; ov = ia.overrun;
    end else begin
      have = (qb.size() != 0);
      if (have) e = qb.pop_front();
      d = ib.data; pe = ib.parity_err; fe = ib.frame_err; ov = ib.overrun;
    end
    if (!have) begin
      check($sformatf("unexpected_valid_%s", tag), 16'd1, 16'd0);
    end else begin
      check($sformatf("data_%s", tag), 16'(d), 16'(e.d));
      check($sformatf("parity_err_%s", tag), 16'(pe), 16'(e.pe));
      check($sformatf("frame_err_%s", tag), 16'(fe), 16'(e.fe));
      check($sformatf("overrun_%s", tag), 16'(ov), 16'(e.ov));
    end
  endtask

  initial begin : mon_a
    forever begin
      @(negedge clk);
      if (ia.valid && !hold_a && !rst) begin
        repeat ($urandom_range(1, 300)) @(negedge clk);
        judge(0);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        check("valid_drop_a", 16'(ia.valid), 16'd0);
      end
    end
  end

  initial begin : mon_b
    forever begin
      @(negedge clk);
      if (ib.valid && !rst) begin
        repeat ($urandom_range(1, 300)) @(negedge clk);
        judge(1);
        rdy_b = 1'b1;
        @(negedge clk);
        rdy_b = 1'b0;
        check("valid_drop_b", 16'(ib.valid), 16'd0);
      end
    end
  end

  task automatic drive(input int ch, input logic v, input int n);
    if (ch == 0) sig_a = v;
    else         sig_b = v;
    repeat (n) @(posedge clk);
  endtask

  // Channel b frames carry a parity bit and two stop bits; the reference uses even parity.
  task automatic send(input int ch, input logic [7:0] d, input logic pbit, input logic stop2,
                      input int gap, input bit expect_it);
    exp_t e;
    e.d  = d;
    e.pe = (ch == 1) && (pbit != ^d);
    e.fe = (ch == 1) && !stop2;
    e.ov = 1'b0;
    if (expect_it) begin
      if (ch == 0) qa.push_back(e);
      else         qb.push_back(e);
    end
    drive(ch, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(ch, d[i], BIT);
    if (ch == 1) begin
      drive(ch, pbit, BIT);
      drive(ch, 1'b1, BIT);
      drive(ch, stop2, BIT);
    end else begin
      drive(ch, 1'b1, BIT);
    end
    drive(ch, 1'b1, gap);
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || ia.valid || ib.valid) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 16'(qa.size() + qb.size() + int'(ia.valid) + int'(ib.valid)), 16'd0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_data_a"}, 16'(ia.data), 16'd0);
    check({tag, "_valid_a"}, 16'(ia.valid), 16'd0);
    check({tag, "_parity_err_a"}, 16'(ia.parity_err), 16'd0);
    check({tag, "_frame_err_a"}, 16'(ia.frame_err), 16'd0);
    check({tag, "_overrun_a"}, 16'(ia.overrun), 16'd0);
    check({tag, "_data_b"}, 16'(ib.data), 16'd0);
    check({tag, "_valid_b"}, 16'(ib.valid), 16'd0);
    check({tag, "_parity_err_b"}, 16'(ib.parity_err), 16'd0);
    check({tag, "_frame_err_b"}, 16'(ib.frame_err), 16'd0);
    check({tag, "_overrun_b"}, 16'(ib.overrun), 16'd0);
  endtask

  initial begin : stim
    exp_t       e;
    logic [7:0] d;
    logic       s;
    logic [7:0] part;

    // Line already low through reset must not start a frame.
    sig_a = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs("reset");
    repeat (3 * BIT) @(posedge clk);
    sig_a = 1'b1;
    repeat (BIT) @(posedge clk);

    send(0, 8'h00, 1'b0, 1'b1, 0, 1'b1);
    send(0, 8'hFF, 1'b0, 1'b1, 0, 1'b1);
    for (int i = 0; i < 40; i++)
      send(0, 8'($urandom), 1'b0, 1'b1, $urandom_range(0, 20), 1'b1);

    send(1, 8'hA5, 1'b0, 1'b1, 0, 1'b1);
    send(1, 8'hA5, 1'b1, 1'b1, 0, 1'b1);
    send(1, 8'h3C, 1'b0, 1'b0, BIT, 1'b1);
    send(1, 8'h3D, 1'b1, 1'b1, 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send(1, d, 1'($urandom_range(0, 1)), s, s ? $urandom_range(0, 20) : BIT, 1'b1);
    end
    drain();

    // Consumer stalled across two back-to-back frames: the second is dropped.
    hold_a = 1'b1;
    send(0, 8'h11, 1'b0, 1'b1, 0, 1'b0);
    send(0, 8'h22, 1'b0, 1'b1, 0, 1'b0);
    e.d = 8'h11; e.pe = 1'b0; e.fe = 1'b0; e.ov = 1'b1;
    qa.push_back(e);
    hold_a = 1'b0;
    drain();
    send(0, 8'h33, 1'b0, 1'b1, 0, 1'b1);
    drain();

    drive(0, 1'b0, 20);
    drive(0, 1'b1, 3 * BIT);
    drive(1, 1'b0, 20);
    drive(1, 1'b1, 3 * BIT);
    send(0, 8'h96, 1'b0, 1'b1, 0, 1'b1);
    send(1, 8'h69, 1'b0, 1'b1, 0, 1'b1);
    drain();

    part = 8'h5A;
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(0, part[i], BIT);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs("abort");
    sig_a = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    send(0, 8'h5A, 1'b0, 1'b1, 0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #(900_000);
    errors++;
    $display("FAIL watchdog: still running at %0t, limit 900000", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
